// File: rtl/ext_mem_responder_pkg.sv
// Shared types and constants for the external memory responder slice.
package ext_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_ADDR   = 32'h1000_0000;
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

endpackage

// File: rtl/ext_mem_ram.sv
// Word RAM with per-byte write enables and a registered (synchronous) read port.
module ext_mem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Read-first: a same-edge write is seen by the following read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr][b] <= wdata[8*b +: 8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Single-outstanding memory responder: RAM window, interrupt control register, bus error on everything else.
module ext_mem_responder
  import ext_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] IRQ_ADDR    = DEF_IRQ_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_valid,
  input  logic        ext_instruction,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_write_data,
  input  logic [3:0]  ext_write_strobe,
  output logic        ext_ready,
  output logic [31:0] ext_read_data,
  output logic        meip,
  output logic        bus_error
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  strb_q;
  logic        meip_q;
  logic        accept, done;
  logic [31:0] off;
  logic        ram_hit, irq_hit, is_write;
  logic [AW-1:0] ram_idx;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic        unused_ok;

  assign unused_ok = ext_instruction;
  assign accept    = (state == IDLE) && ext_valid;
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (ext_valid) begin
        cnt_nxt   = 4'(WAIT_CYCLES);
        state_nxt = (WAIT_CYCLES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
    end else if (accept) begin
      addr_q  <= ext_address;
      wdata_q <= ext_write_data;
      strb_q  <= ext_write_strobe;
    end
  end

  assign off      = addr_q - BASE_ADDR;
  assign ram_hit  = (addr_q >= BASE_ADDR) && (off < RAM_BYTES);
  assign irq_hit  = !ram_hit && (addr_q[31:2] == IRQ_ADDR[31:2]);
  assign is_write = |strb_q;

  // In IDLE the RAM is addressed straight from the bus so read data is ready even with zero wait states.
  assign ram_idx = (state == IDLE) ? AW'((ext_address - BASE_ADDR) >> 2) : AW'(off >> 2);
  assign ram_we  = (done && ram_hit) ? strb_q : 4'b0000;

  ext_mem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            meip_q <= 1'b0;
    else if (done && irq_hit && strb_q[0]) meip_q <= wdata_q[0];
  end

  always_comb begin
    ext_read_data = UNMAPPED_RDATA;
    if (done && !is_write) begin
      if (ram_hit)      ext_read_data = ram_rdata;
      else if (irq_hit) ext_read_data = {31'b0, meip_q};
    end
  end

  assign ext_ready = done;
  assign bus_error = done && !ram_hit && !irq_hit;
  assign meip      = meip_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench with a scoreboard queue; one responder with one wait state, one with none.
module tb_ext_mem_responder;

  localparam int W1 = 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   exp_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, instr = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic [3:0]  strb = '0;
  logic        ready, meip, berr;
  logic [31:0] rdata;

  logic        valid0 = 1'b0, instr0 = 1'b0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic [3:0]  strb0 = '0;
  logic        ready0, meip0, berr0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  ext_mem_responder #(.WAIT_CYCLES(W1)) dut (
    .clk(clk), .reset(rst_n), .ext_valid(valid), .ext_instruction(instr),
    .ext_address(addr), .ext_write_data(wd), .ext_write_strobe(strb),
    .ext_ready(ready), .ext_read_data(rdata), .meip(meip), .bus_error(berr)
  );

  ext_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .ext_valid(valid0), .ext_instruction(instr0),
    .ext_address(addr0), .ext_write_data(wd0), .ext_write_strobe(strb0),
    .ext_ready(ready0), .ext_read_data(rdata0), .meip(meip0), .bus_error(berr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request on dut at a negedge, wait (bounded) for ready, score against the queue.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] erd, input logic eerr, input bit skip_wait, input bit drop);
    exp_t e;
    int   lat;
    e.rd = erd; e.err = eerr; e.lat = 1 + W1;
    sb.push_back(e);
    if (!skip_wait) @(negedge clk);
    valid = 1'b1; addr = a; wd = d; strb = s; instr = ~|s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (drop) valid = 1'b0;
      if (!ready) chk("rdata_zero_not_ready", rdata, 32'h0);
    end while (!ready && lat < 20);
    valid = 1'b0;
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rdata", rdata, e.rd);
    chk("bus_error", {31'b0, berr}, {31'b0, e.err});
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_berr", {31'b0, berr}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_meip", {31'b0, meip}, 32'h0);
    chk("rst_ready0", {31'b0, ready0}, 32'h0);

    // first request in the first cycle after reset release
    rst_n = 1'b1;
    txn(32'h8000_0010, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(32'h8000_0010, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);

    // partial-lane write
    txn(32'h8000_0014, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0014, 32'hAAAA_AAAA, 4'b0101, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0016, 32'h0, 4'h0, 32'h11AA_33AA, 1'b0, 1'b0, 1'b0);

    // unmapped and window edges
    txn(32'h0000_0100, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    txn(32'h8000_1000, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0);
    txn(32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    txn(32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0FFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0000, 32'h7777_0000, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0000, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0010, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);

    // interrupt control register
    txn(32'h1000_0000, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("meip_at_ready", {31'b0, meip}, 32'h0);
    @(negedge clk);
    chk("meip_set", {31'b0, meip}, 32'h1);
    txn(32'h1000_0000, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    txn(32'h1000_0000, 32'h1, 4'b1110, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("meip_hold_no_lane0", {31'b0, meip}, 32'h1);
    txn(32'h1000_0000, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("meip_clear", {31'b0, meip}, 32'h0);

    // valid dropped during WAIT still completes and commits
    txn(32'h8000_0024, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1);
    txn(32'h8000_0024, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);

    // reset during WAIT aborts the write
    txn(32'h8000_0020, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b1; addr = 32'h8000_0020; wd = 32'hDEAD_BEEF; strb = 4'hF;
    @(negedge clk);
    chk("abort_wait_ready", {31'b0, ready}, 32'h0);
    rst_n = 1'b0; valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ready", {31'b0, ready}, 32'h0);
    end
    rst_n = 1'b1;
    txn(32'h8000_0020, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0010, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);

    // zero wait states, valid held high across three requests
    @(negedge clk);
    valid0 = 1'b1; addr0 = 32'h8000_0040; wd0 = 32'hA000_0000; strb0 = 4'hF;
    exp_cyc.push_back(1);
    begin
      int k = 0;
      for (int c = 1; c <= 10 && k < 3; c++) begin
        @(negedge clk);
        if (ready0) begin
          chk("w0_ready_cycle", 32'(c), 32'(exp_cyc.pop_front()));
          chk("w0_berr", {31'b0, berr0}, 32'h0);
          k++;
          if (k == 3) valid0 = 1'b0;
          else begin
            addr0 = 32'h8000_0040 + 32'(4 * k);
            wd0   = 32'hA000_0000 + 32'(k);
            exp_cyc.push_back(1 + 2 * k);
          end
        end
      end
      chk("w0_ready_count", 32'(k), 32'd3);
    end
    @(negedge clk);
    valid0 = 1'b1; addr0 = 32'h8000_0044; strb0 = 4'h0;
    @(negedge clk);
    valid0 = 1'b0;
    chk("w0_read_ready", {31'b0, ready0}, 32'h1);
    chk("w0_read_data", rdata0, 32'hA000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
